// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports and single-port RAM bus shared by mem_port_arbiter.
// Modports: slave = arbiter side, master = core requesters plus RAM model.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;
    logic            if_stall;

    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            ram_en;
    logic [DW/8-1:0] ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_stall,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_stall,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port sync RAM between fetch and load/store ports.
// Ports: clk, rst (sync, active-low), bus (mem_port_arbiter_if.slave).
// Optional MEM_ARB_FAIR_EN: fetch gets a turn after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);

    if (DW % 8 != 0) begin : g_dw_chk
        $error("DW must be a multiple of 8");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_sm_chk
        $error("STARVE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_e;

    owner_e owner;
    logic   both;
    logic   pick_if;
    logic   pick_d;

    assign both = bus.if_req & bus.d_req;

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] starve_cnt;
    logic       fair_turn;

    assign fair_turn = both & (starve_cnt == 4'(STARVE_MAX));
    assign pick_if   = rst & bus.if_req & (~bus.d_req | fair_turn);

    always_ff @(posedge clk) begin
        if (!rst || pick_if || !bus.if_req)
            starve_cnt <= 4'd0;
        else if (both && pick_d)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    assign pick_if = rst & bus.if_req & ~bus.d_req;
`endif

    assign pick_d = rst & bus.d_req & ~pick_if;

    assign bus.if_gnt    = pick_if;
    assign bus.d_gnt     = pick_d;
    assign bus.if_stall  = bus.if_req & ~pick_if;

    assign bus.ram_en    = pick_if | pick_d;
    assign bus.ram_we    = (pick_d & bus.d_we) ? bus.d_be : '0;
    assign bus.ram_addr  = pick_if ? bus.if_addr : bus.d_addr;
    assign bus.ram_wdata = bus.d_wdata;

    // Gating with rst drops a return whose grant preceded reset.
    assign bus.if_rvalid = rst & (owner == OWN_IF);
    assign bus.d_rvalid  = rst & (owner == OWN_D);
    assign bus.if_rdata  = bus.ram_rdata;
    assign bus.d_rdata   = bus.ram_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner <= OWN_NONE;
        end else begin
            unique case (1'b1)
                pick_if:             owner <= OWN_IF;
                pick_d & ~bus.d_we:  owner <= OWN_D;
                default:             owner <= OWN_NONE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a behavioural RAM.
// Expected grants and read data come from a shadow memory and priority rules.
module tb_mem_port_arbiter;

    localparam int SM = 3;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];
    exp_t        ifq[$];
    exp_t        dq[$];
    int          streak = 0;
    bit          last_gi = 1'b0;
    bit          last_gd = 1'b0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_MAX(SM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural single-port RAM
    always @(posedge clk) begin
        if (bus.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b])
                    mem[bus.ram_addr[9:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            bus.ram_rdata <= mem[bus.ram_addr[9:2]];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Compare combinational outputs against the priority rules and
    // record expected read returns.
    task automatic check_cycle();
        bit gi, gd, both;
        logic [3:0]  exp_we;
        logic [31:0] w;
        both = bus.if_req && bus.d_req;
        gi = 1'b0;
        gd = 1'b0;
        if (rst) begin
            if (both) begin
                if (FAIR && streak == SM) gi = 1'b1;
                else gd = 1'b1;
            end else begin
                gi = bus.if_req;
                gd = bus.d_req;
            end
        end
        chk("if_gnt", bus.if_gnt, gi);
        chk("d_gnt", bus.d_gnt, gd);
        chk("ram_en", bus.ram_en, gi | gd);
        chk("if_stall", bus.if_stall, bus.if_req & ~gi);
        exp_we = (gd && bus.d_we) ? bus.d_be : 4'b0;
        chk("ram_we", bus.ram_we, exp_we);
        if (gi) begin
            chk("ram_addr_if", bus.ram_addr, bus.if_addr);
            ifq.push_back('{cyc + 1, shadow[bus.if_addr[9:2]]});
        end
        if (gd) begin
            chk("ram_addr_d", bus.ram_addr, bus.d_addr);
            if (bus.d_we) begin
                chk("ram_wdata", bus.ram_wdata, bus.d_wdata);
                w = shadow[bus.d_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (bus.d_be[b]) w[8*b +: 8] = bus.d_wdata[8*b +: 8];
                shadow[bus.d_addr[9:2]] = w;
            end else begin
                dq.push_back('{cyc + 1, shadow[bus.d_addr[9:2]]});
            end
        end
        if (!rst || gi || !bus.if_req) streak = 0;
        else if (both && gd) streak++;
        last_gi = gi;
        last_gd = gd;
    endtask

    task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dwe, input logic [3:0] dbe,
                        input logic [31:0] da, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        rst         = r;
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dwe;
        bus.d_be    = dbe;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        if (!r) begin
            ifq.delete();
            dq.delete();
        end
        @(negedge clk);
        check_cycle();
    endtask

    // Monitor: pops the scoreboard whenever a read return appears and
    // flags returns that are missing, late or unexpected.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.if_rvalid) begin
                if (ifq.size() == 0 || ifq[0].due != cyc) begin
                    chk("if_rvalid_unexpected", 1, 0);
                end else begin
                    e = ifq.pop_front();
                    chk("if_rdata", bus.if_rdata, e.data);
                end
            end else if (ifq.size() != 0 && ifq[0].due <= cyc) begin
                void'(ifq.pop_front());
                chk("if_rvalid_missing", 0, 1);
            end
            if (bus.d_rvalid) begin
                if (dq.size() == 0 || dq[0].due != cyc) begin
                    chk("d_rvalid_unexpected", 1, 0);
                end else begin
                    e = dq.pop_front();
                    chk("d_rdata", bus.d_rdata, e.data);
                end
            end else if (dq.size() != 0 && dq[0].due <= cyc) begin
                void'(dq.pop_front());
                chk("d_rvalid_missing", 0, 1);
            end
        end
    end

    initial begin
        bit          ir, dr, dwe;
        logic [31:0] ia, da, dwd;
        logic [3:0]  dbe;

        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'h5A00_0000 ^ (i * 32'h0001_0203);
            shadow[i] = mem[i];
        end
        mem[16]    = 32'h2008_0005;
        shadow[16] = 32'h2008_0005;
        mem[64]    = 32'h1122_3344;
        shadow[64] = 32'h1122_3344;
        bus.ram_rdata = '0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_be    = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset held with both requesting
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h40, 1, 0, 4'hF, 32'h100, 0);
            chk("rst_if_rvalid", bus.if_rvalid, 0);
            chk("rst_d_rvalid", bus.d_rvalid, 0);
        end
        step(1, 1, 32'h40, 1, 0, 4'hF, 32'h100, 0);
        // Fetch only
        step(1, 1, 32'h40, 0, 0, 4'h0, 32'h0, 0);
        step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 0);
        // Partial write then read back
        step(1, 0, 32'h0, 1, 1, 4'b0011, 32'h100, 32'hAABB_CCDD);
        step(1, 0, 32'h0, 1, 0, 4'h0, 32'h100, 0);
        step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 0);
        chk("merged_word", shadow[64], 32'h1122_CCDD);
        // Conflict for 5 cycles, then data drops
        for (int i = 0; i < 5; i++)
            step(1, 1, 32'h40, 1, 0, 4'hF, 32'h20, 0);
        step(1, 1, 32'h40, 0, 0, 4'h0, 32'h0, 0);
        step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 0);
        // Sustained conflict: exposes the fairness pattern when enabled
        for (int i = 0; i < 8; i++)
            step(1, 1, 32'h44, 1, 0, 4'hF, 32'h24, 0);
        // Write with no byte enables
        step(1, 0, 32'h0, 1, 1, 4'b0000, 32'h30, 32'hDEAD_BEEF);
        // Reset in the cycle after a read grant
        step(1, 0, 32'h0, 1, 0, 4'hF, 32'h100, 0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 0);
        chk("rst_mid_d_rvalid", bus.d_rvalid, 0);
        step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 0);
        chk("post_rst_d_rvalid", bus.d_rvalid, 0);

        // Random traffic obeying the hold-until-grant rule
        ir = 0; dr = 0; dwe = 0; dbe = 0; ia = 0; da = 0; dwd = 0;
        for (int n = 0; n < 600; n++) begin
            if (ir && !last_gi) begin
                if ($urandom_range(0, 9) == 0) ir = 0;
            end else begin
                ir = ($urandom_range(0, 9) < 6);
                ia = 32'($urandom_range(0, 255)) << 2;
            end
            if (dr && !last_gd) begin
                if ($urandom_range(0, 9) == 0) dr = 0;
            end else begin
                dr  = ($urandom_range(0, 9) < 6);
                dwe = $urandom_range(0, 1);
                dbe = 4'($urandom_range(0, 15));
                da  = 32'($urandom_range(0, 255)) << 2;
                dwd = $urandom;
            end
            step(1, ir, ia, dr, dwe, dbe, da, dwd);
        end

        for (int i = 0; i < 3; i++)
            step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 0);
        chk("if_queue_drained", ifq.size(), 0);
        chk("d_queue_drained", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
